// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory-access stage: bus widths, stall
// encoding, load_type codes and the EX->MEM bus field layout.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 80;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int StallBus     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Stall vector bit positions owned by this stage and its successor.
  localparam int STALL_MEM_BIT = 3;
  localparam int STALL_WB_BIT  = 4;

  localparam logic [3:0] LT_NONE = 4'b0000;
  localparam logic [3:0] LT_LB   = 4'b0001;
  localparam logic [3:0] LT_LBU  = 4'b0010;
  localparam logic [3:0] LT_LH   = 4'b0011;
  localparam logic [3:0] LT_LHU  = 4'b0100;
  localparam logic [3:0] LT_LW   = 4'b1111;

  typedef struct packed {
    logic [3:0]  load_type;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  // Unrecognised codes behave exactly like "no load".
  function automatic logic is_load(input logic [3:0] lt);
    case (lt)
      LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LW: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bus bundle between the memory stage and its neighbours (EX, SRAM, WB, ID).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [StallBus-1:0]     stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;

  modport master (
    output stall,
    output ex_to_mem_bus,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_id_bus
  );

  modport slave (
    input  stall,
    input  ex_to_mem_bus,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_id_bus
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the SRAM word
// and sign- or zero-extends it according to load_type.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  load_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] wdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Halfword loads ignore addr_lo[0].
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wdata = 32'h0;
    case (load_type)
      LT_LB:   wdata = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  wdata = {24'h0, byte_sel};
      LT_LH:   wdata = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  wdata = {16'h0, half_sel};
      LT_LW:   wdata = rdata;
      default: wdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX->MEM pipeline register, stall-safe hold of the
// returned SRAM word, result select and packing of the WB / ID forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  mif
);

  ex_mem_t     bus_q, bus_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;

  logic        mem_stall;
  logic        wb_stall;
  logic [31:0] rdata_eff;
  logic [31:0] load_wdata;
  logic [31:0] rf_wdata;
  logic        use_load;

  assign mem_stall = (mif.stall[STALL_MEM_BIT] == STOP);
  assign wb_stall  = (mif.stall[STALL_WB_BIT] == STOP);

  always_comb begin
    bus_d = bus_q;
    if (rst) begin
      bus_d = '0;
    end else if (mem_stall && !wb_stall) begin
      bus_d = '0;
    end else if (!mem_stall) begin
      bus_d = ex_mem_t'(mif.ex_to_mem_bus);
    end
  end

  // The SRAM only presents read data for one cycle; keep the first stalled
  // cycle's word so a long stall still writes back the right value.
  always_comb begin
    hold_valid_d = hold_valid_q;
    rdata_hold_d = rdata_hold_q;
    if (rst) begin
      hold_valid_d = 1'b0;
      rdata_hold_d = 32'h0;
    end else if (mem_stall && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      rdata_hold_d = mif.data_sram_rdata;
    end else if (!mem_stall) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    bus_q        <= bus_d;
    hold_valid_q <= hold_valid_d;
    rdata_hold_q <= rdata_hold_d;
  end

  assign rdata_eff = hold_valid_q ? rdata_hold_q : mif.data_sram_rdata;

  load_align u_load_align (
    .load_type (bus_q.load_type),
    .addr_lo   (bus_q.ex_result[1:0]),
    .rdata     (rdata_eff),
    .wdata     (load_wdata)
  );

  assign use_load = bus_q.sel_rf_res && bus_q.ram_en && is_load(bus_q.load_type);
  assign rf_wdata = use_load ? load_wdata : bus_q.ex_result;

  assign mif.mem_to_wb_bus = {bus_q.pc, bus_q.rf_we, bus_q.rf_waddr, rf_wdata};
  assign mif.mem_to_id_bus = {bus_q.rf_we, bus_q.rf_waddr, rf_wdata};

  // Store byte enables and other stages' stall bits are not consumed here.
  logic unused_bits;
  assign unused_bits = ^{bus_q.ram_wen, mif.stall[5], mif.stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random traffic
// compared against a behavioural model of the stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus_if ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .mif (bus_if.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [79:0] m_bus;
  logic        m_hv;
  logic [31:0] m_hold;

  function automatic logic [79:0] mk(input logic [3:0] lt, input logic [31:0] pc,
                                     input logic ram_en, input logic sel,
                                     input logic we, input logic [4:0] waddr,
                                     input logic [31:0] res);
    return {lt, pc, ram_en, 4'h0, sel, we, waddr, res};
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [79:0] b, input logic [31:0] live);
    logic [31:0] src, v;
    int unsigned lane;
    src = m_hv ? m_hold : live;
    if (!(b[38] && b[43])) return b[31:0];
    case (b[79:76])
      4'b0001: begin
        lane = b[1:0];
        v = (src >> (8 * lane)) & 32'hFF;
        if (v >= 32'd128) v = v + 32'hFFFFFF00;
        return v;
      end
      4'b0010: begin
        lane = b[1:0];
        return (src >> (8 * lane)) & 32'hFF;
      end
      4'b0011: begin
        lane = b[1];
        v = (src >> (16 * lane)) & 32'hFFFF;
        if (v >= 32'd32768) v = v + 32'hFFFF0000;
        return v;
      end
      4'b0100: begin
        lane = b[1];
        return (src >> (16 * lane)) & 32'hFFFF;
      end
      4'b1111: return src;
      default: return b[31:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [79:0] ex, input logic [5:0] st,
                       input logic [31:0] rd, input logic r, input string tag);
    logic [31:0] wd;
    bus_if.ex_to_mem_bus   = ex;
    bus_if.stall           = st;
    bus_if.data_sram_rdata = rd;
    rst                    = r;
    #1;
    wd = ref_wdata(m_bus, rd);
    chk({tag, "_wb"}, bus_if.mem_to_wb_bus, {m_bus[75:44], m_bus[37], m_bus[36:32], wd});
    chk({tag, "_id"}, 70'(bus_if.mem_to_id_bus), 70'({m_bus[37], m_bus[36:32], wd}));
  endtask

  task automatic tick();
    logic [79:0] nb;
    logic        nhv;
    logic [31:0] nh;
    nb = m_bus; nhv = m_hv; nh = m_hold;
    if (rst) begin
      nb = '0; nhv = 1'b0; nh = '0;
    end else begin
      if (bus_if.stall[3] && !m_hv) begin
        nh = bus_if.data_sram_rdata; nhv = 1'b1;
      end else if (!bus_if.stall[3]) begin
        nhv = 1'b0;
      end
      if (bus_if.stall[3] && !bus_if.stall[4]) nb = '0;
      else if (!bus_if.stall[3]) nb = bus_if.ex_to_mem_bus;
    end
    @(posedge clk);
    m_bus = nb; m_hv = nhv; m_hold = nh;
    #1;
  endtask

  logic [79:0] nop, lw, alu;
  logic [3:0]  sw_lt  [4] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100};
  logic [1:0]  sw_ad  [4] = '{2'd2, 2'd3, 2'd2, 2'd0};
  logic [31:0] sw_exp [4] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
  logic [3:0]  codes  [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1111};

  initial begin
    m_bus = '0; m_hv = 1'b0; m_hold = '0;
    nop = '0;
    rst = 1'b1;
    bus_if.ex_to_mem_bus = '0;
    bus_if.stall = '0;
    bus_if.data_sram_rdata = '0;
    tick();
    tick();

    // reset state, then LW with no stall
    lw = mk(4'b1111, 32'h0040_0010, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_1000);
    drive(lw, 6'b0, 32'h5555_5555, 1'b0, "reset");
    chk("reset_wb_zero", bus_if.mem_to_wb_bus, 70'h0);
    chk("reset_id_zero", 70'(bus_if.mem_to_id_bus), 70'h0);
    tick();
    drive(nop, 6'b0, 32'hDEAD_BEEF, 1'b0, "lw");
    chk("lw_wdata", 70'(bus_if.mem_to_wb_bus[31:0]), 70'h0DEAD_BEEF);
    chk("lw_we", 70'(bus_if.mem_to_wb_bus[37]), 70'h1);
    chk("lw_waddr", 70'(bus_if.mem_to_wb_bus[36:32]), 70'd9);
    chk("lw_pc", 70'(bus_if.mem_to_wb_bus[69:38]), 70'h0040_0010);
    tick();

    // sub-word loads on 0x80FF7F01
    for (int i = 0; i < 4; i++) begin
      drive(mk(sw_lt[i], 32'h100 + 32'(i), 1'b1, 1'b1, 1'b1, 5'd3, {30'h400, sw_ad[i]}),
            6'b0, 32'h0, 1'b0, "sw_cap");
      tick();
      drive(nop, 6'b0, 32'h80FF_7F01, 1'b0, "sw");
      chk("subword_wdata", 70'(bus_if.mem_to_wb_bus[31:0]), 70'(sw_exp[i]));
      tick();
    end

    // ALU result goes straight through
    alu = mk(4'b0000, 32'h200, 1'b0, 1'b0, 1'b1, 5'd17, 32'h1234_5678);
    drive(alu, 6'b0, 32'hFFFF_FFFF, 1'b0, "alu_cap");
    tick();
    drive(nop, 6'b0, 32'hFFFF_FFFF, 1'b0, "alu");
    chk("alu_wb_wdata", 70'(bus_if.mem_to_wb_bus[31:0]), 70'h1234_5678);
    chk("alu_id_wdata", 70'(bus_if.mem_to_id_bus[31:0]), 70'h1234_5678);
    tick();

    // LW held across a 3-cycle MEM+WB stall and the release cycle
    drive(lw, 6'b0, 32'h0, 1'b0, "stl_cap");
    tick();
    drive(alu, 6'b011000, 32'hAAAA_0001, 1'b0, "stl1");
    chk("stall_c1", 70'(bus_if.mem_to_wb_bus[31:0]), 70'hAAAA_0001);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(alu, 6'b011000, 32'h0, 1'b0, "stln");
      chk("stall_cn", 70'(bus_if.mem_to_wb_bus[31:0]), 70'hAAAA_0001);
      tick();
    end
    drive(alu, 6'b0, 32'h0, 1'b0, "stl_rel");
    chk("stall_release", 70'(bus_if.mem_to_wb_bus[31:0]), 70'hAAAA_0001);
    tick();

    // MEM stalled, WB running: bubble
    drive(lw, 6'b001000, 32'h0, 1'b0, "bub_in");
    tick();
    drive(nop, 6'b0, 32'hCAFE_F00D, 1'b0, "bub");
    chk("bubble_wb", bus_if.mem_to_wb_bus, 70'h0);
    chk("bubble_id", 70'(bus_if.mem_to_id_bus), 70'h0);
    chk("bubble_no_fwd", 70'(bus_if.mem_to_id_bus[37]), 70'h0);
    tick();

    // reset in the middle of a stalled load
    drive(lw, 6'b0, 32'h0, 1'b0, "rs_cap");
    tick();
    drive(nop, 6'b011000, 32'h1111_2222, 1'b0, "rs_stl");
    tick();
    drive(nop, 6'b011000, 32'h0, 1'b1, "rs_rst");
    tick();
    drive(lw, 6'b0, 32'h0, 1'b0, "rs_after");
    chk("rst_wb_zero", bus_if.mem_to_wb_bus, 70'h0);
    chk("rst_id_zero", 70'(bus_if.mem_to_id_bus), 70'h0);
    chk("rst_hold_valid", 70'(dut.hold_valid_q), 70'h0);
    tick();
    drive(nop, 6'b0, 32'h3333_4444, 1'b0, "rs_live");
    chk("rst_live_data", 70'(bus_if.mem_to_wb_bus[31:0]), 70'h3333_4444);
    tick();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [79:0] ex;
      logic [5:0]  st;
      ex = mk(codes[$urandom_range(0, 5)], $urandom, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom), $urandom);
      st = 6'($urandom);
      st[3] = ($urandom_range(0, 3) == 0);
      drive(ex, st, $urandom, ($urandom_range(0, 49) == 0), "rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
